// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory, with timeout-to-error.
// Define DATA_MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 0.
module data_mem_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req0,
    input  logic            i_req1,
    input  logic [XLEN-1:0] i_addr0,
    input  logic [XLEN-1:0] i_addr1,
    input  logic [XLEN-1:0] i_wdata0,
    input  logic [XLEN-1:0] i_wdata1,
    input  logic [2:0]      i_funct3_0,
    input  logic [2:0]      i_funct3_1,
    input  logic            i_read_write0,
    input  logic            i_read_write1,
    output logic            or_ack0,
    output logic            or_ack1,
    output logic            or_err0,
    output logic            or_err1,
    output logic [XLEN-1:0] or_rdata0,
    output logic [XLEN-1:0] or_rdata1,
    output logic            or_mem_req,
    output logic [XLEN-1:0] or_mem_addr,
    output logic [XLEN-1:0] or_mem_data,
    output logic [2:0]      or_mem_funct3,
    output logic            or_mem_read_write,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_data,
    output logic            or_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t          state, state_next;
    logic            take, done_ok, done_to, cnt_inc;
    logic            pick1, winner;
    logic [7:0]      cnt;
    logic [XLEN-1:0] resp_data;

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    // rr_ptr = 1 means requester 1 is preferred on the next tie.
    logic rr_ptr;
    assign pick1 = i_req1 & (~i_req0 | rr_ptr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  rr_ptr <= 1'b0;
        else if (take) rr_ptr <= ~pick1;
    end
`else
    assign pick1 = ~i_req0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    take       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // A memory ack on the timeout cycle still counts as a normal completion.
                if (i_mem_ack) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_inc    = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign resp_data = (done_ok && or_mem_read_write) ? i_mem_data : '0;
    assign or_busy   = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            or_mem_req        <= 1'b0;
            or_mem_addr       <= '0;
            or_mem_data       <= '0;
            or_mem_funct3     <= '0;
            or_mem_read_write <= 1'b0;
            winner            <= 1'b0;
            cnt               <= '0;
            or_ack0           <= 1'b0;
            or_ack1           <= 1'b0;
            or_err0           <= 1'b0;
            or_err1           <= 1'b0;
            or_rdata0         <= '0;
            or_rdata1         <= '0;
        end else begin
            if (take) begin
                or_mem_req        <= 1'b1;
                or_mem_addr       <= pick1 ? i_addr1       : i_addr0;
                or_mem_data       <= pick1 ? i_wdata1      : i_wdata0;
                or_mem_funct3     <= pick1 ? i_funct3_1    : i_funct3_0;
                or_mem_read_write <= pick1 ? i_read_write1 : i_read_write0;
                winner            <= pick1;
                cnt               <= '0;
            end
            if (cnt_inc) cnt <= cnt + 8'd1;
            if (done_ok || done_to) begin
                or_mem_req <= 1'b0;
                if (winner) begin
                    or_ack1   <= 1'b1;
                    or_err1   <= done_to;
                    or_rdata1 <= resp_data;
                end else begin
                    or_ack0   <= 1'b1;
                    or_err0   <= done_to;
                    or_rdata0 <= resp_data;
                end
            end
            if (state == RESP) begin
                or_ack0 <= 1'b0;
                or_ack1 <= 1'b0;
                or_err0 <= 1'b0;
                or_err1 <= 1'b0;
            end
        end
    end

endmodule
